// File: rtl/shift_feed_pkg.sv
// Shared sizing helpers and parameter legality check for the shift feed FIFO.
package shift_feed_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/shift_feed_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module shift_feed_mem
    import shift_feed_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clock,
    input  logic                        wr_en,
    input  logic [ptr_width(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [ptr_width(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]            rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/shift_feed_fifo.sv
// Registered-output FIFO feeding a shift register; optional flush port
// enabled by defining SHIFT_FEED_FIFO_FLUSH_EN.
module shift_feed_fifo
    import shift_feed_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
`ifdef SHIFT_FEED_FIFO_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("shift_feed_fifo: DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] head;
    logic             clear;
    logic             wr;
    logic             rd;

`ifdef SHIFT_FEED_FIFO_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? head : '0;

    // Reset and flush both suppress the handshakes of that cycle.
    assign wr = in_valid && in_ready && reset && !clear;
    assign rd = out_valid && out_ready && reset && !clear;

    shift_feed_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clock  (clock),
        .wr_en  (wr),
        .wr_addr(wr_ptr),
        .wr_data(in_data),
        .rd_addr(rd_ptr),
        .rd_data(head)
    );

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_feed_fifo.sv
// Self-checking bench for shift_feed_fifo against a queue-based reference model.
module tb_shift_feed_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic             clock;
    logic             reset;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;

    int checks;
    int fails;
    int max_count;
    logic [WIDTH-1:0] model [$];

    shift_feed_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
`ifdef SHIFT_FEED_FIFO_FLUSH_EN
        .flush    (flush),
`endif
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [WIDTH-1:0] head;
        head = (model.size() > 0) ? model[0] : '0;
        check({tag, ".count"}, 32'(count), 32'(model.size()));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(model.size() != 0));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(model.size() != DEPTH));
        check({tag, ".out_data"}, 32'(out_data), 32'(head));
    endtask

    // One clock: drive inputs, check current outputs, advance, update model.
    task automatic step(input string tag, input logic rst_n, input logic fl,
                        input logic vin, input logic [WIDTH-1:0] din,
                        input logic ordy);
        bit do_wr;
        bit do_rd;
        reset     = rst_n;
        flush     = fl;
        in_valid  = vin;
        in_data   = din;
        out_ready = ordy;
        #1;
        check_outputs(tag);
        do_wr = vin && (model.size() < DEPTH);
        do_rd = ordy && (model.size() > 0);
        @(posedge clock);
        #1;
`ifdef SHIFT_FEED_FIFO_FLUSH_EN
        if (!rst_n || fl) begin
`else
        if (!rst_n) begin
`endif
            model.delete();
        end else begin
            if (do_rd) void'(model.pop_front());
            if (do_wr) model.push_back(din);
        end
        if (model.size() > max_count) max_count = model.size();
    endtask

    task automatic do_reset();
        step("reset", 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step("reset", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        max_count = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        do_reset();
        check("reset.count", 32'(count), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_data", 32'(out_data), 32'd0);

        step("wr11", 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
        check("latency.out_valid", 32'(out_valid), 32'd1);
        check("latency.out_data", 32'(out_data), 32'h11);
        step("wr22", 1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
        step("wr33", 1'b1, 1'b0, 1'b1, 8'h33, 1'b0);
        check("three.count", 32'(count), 32'd3);
        check("three.out_data", 32'(out_data), 32'h11);

        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step("fill", 1'b1, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step("full_hold", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
        end
        check("full.in_ready", 32'(in_ready), 32'd0);
        check("full.count", 32'(count), 32'd4);
        check("full.out_data", 32'(out_data), 32'hA0);
        step("full_rdwr", 1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
        check("full_rdwr.count", 32'(count), 32'd3);
        check("full_rdwr.in_ready", 32'(in_ready), 32'd1);
        check("full_rdwr.out_data", 32'(out_data), 32'hA1);
        for (int i = 0; i < 4; i++) begin
            step("drain", 1'b1, 1'b0, 1'b0, '0, 1'b1);
        end
        check("drained.count", 32'(count), 32'd0);
        step("empty_rd", 1'b1, 1'b0, 1'b0, '0, 1'b1);

        do_reset();
        max_count = 0;
        for (int i = 0; i < 16; i++) begin
            step("stream", 1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
            check("stream.out_data", 32'(out_data), 32'(i));
        end
        step("stream_end", 1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("stream.max_count", 32'(max_count), 32'd1);

        do_reset();
        step("pre_rst", 1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        step("pre_rst", 1'b1, 1'b0, 1'b1, 8'h02, 1'b0);
        step("pre_rst", 1'b1, 1'b0, 1'b1, 8'h03, 1'b0);
        step("mid_rst", 1'b0, 1'b0, 1'b1, 8'h04, 1'b1);
        check("mid_rst.count", 32'(count), 32'd0);
        check("mid_rst.out_valid", 32'(out_valid), 32'd0);
        check("mid_rst.out_data", 32'(out_data), 32'd0);
        check("mid_rst.in_ready", 32'(in_ready), 32'd1);

`ifdef SHIFT_FEED_FIFO_FLUSH_EN
        step("pre_fl", 1'b1, 1'b0, 1'b1, 8'h21, 1'b0);
        step("pre_fl", 1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
        step("flush", 1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
        check("flush.count", 32'(count), 32'd0);
        check("flush.out_valid", 32'(out_valid), 32'd0);
        step("post_fl", 1'b1, 1'b0, 1'b0, '0, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            step("random",
                 ($urandom_range(0, 59) != 0),
`ifdef SHIFT_FEED_FIFO_FLUSH_EN
                 ($urandom_range(0, 59) == 0),
`else
                 1'b0,
`endif
                 1'($urandom),
                 8'($urandom),
                 1'($urandom));
        end
        check_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/shift_feed_fifo.md
SHIFT_FEED_FIFO -- requirements
Module: shift_feed_fifo

Interface
- REQ-001: Parameter WIDTH, default 8, data word width in bits; matches the downstream shift_register WIDTH.
- REQ-002: Parameter DEPTH, default 4, number of storage entries; power of two, at least 2.
- REQ-003: Port clock, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-004: Port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clock.
- REQ-005: Port in_data, input, WIDTH bits: write word from the producer.
- REQ-006: Port in_valid, input, 1 bit: producer offers in_data this cycle.
- REQ-007: Port in_ready, output, 1 bit: FIFO can accept a word this cycle.
- REQ-008: Port out_data, output, WIDTH bits: head word; drives shift_register data_in.
- REQ-009: Port out_valid, output, 1 bit: out_data holds a stored word.
- REQ-010: Port out_ready, input, 1 bit: consumer takes the head word this cycle.
- REQ-011: Port count, output, $clog2(DEPTH)+1 bits: number of stored words, 0..DEPTH.

Function
- REQ-012: Write accepted when in_valid && in_ready; the word is stored at the write pointer, and the write pointer increments modulo DEPTH.
- REQ-013: Read accepted when out_valid && out_ready; the read pointer increments modulo DEPTH.
- REQ-014: in_ready = (count != DEPTH); combinational from registered state only, with no dependence on out_ready.
- REQ-015: out_valid = (count != 0); out_data = stored word at the read pointer when out_valid is 1, otherwise all zeros.
- REQ-016: Latency: a word written into an empty FIFO appears on out_data with out_valid = 1 in the cycle after acceptance; there is no same-cycle fall-through.
- REQ-017: Order: words leave in exactly the order they were accepted; no loss or duplication.
- REQ-018: count update per cycle:
  - +1 on write only;
  - -1 on read only;
  - unchanged on simultaneous write and read, or on neither.
- REQ-019: Full (count = DEPTH): in_valid is ignored; a read in the same cycle frees a slot only from the next cycle on.
- REQ-020: Empty (count = 0): out_ready is ignored; a write in the same cycle is stored and nothing is read.
- REQ-021: Pointer wrap-around: both pointers wrap from DEPTH-1 to 0 with no bubble or throughput loss.
- REQ-022: Throughput: sustained one word per cycle when neither full nor empty.

Reset
- REQ-023: While reset = 0 at a rising edge:
  - read pointer, write pointer and count clear to 0;
  - outputs become in_ready = 1, out_valid = 0, out_data = 0, count = 0.
- REQ-024: Reset mid-operation discards all stored words; in_valid and out_ready are ignored in the reset cycle.
- REQ-025: Storage array is not reset; its contents are unobservable while count = 0.

Configuration
- REQ-026: Macro SHIFT_FEED_FIFO_FLUSH_EN defined adds input port flush, 1 bit. flush = 1 at an edge clears pointers and count exactly as reset does, and overrides any same-cycle write or read.
- REQ-027: Macro SHIFT_FEED_FIFO_FLUSH_EN undefined: no flush port; only reset clears state.

Structure
- REQ-028: Shared package shift_feed_pkg holds:
  - pointer-width and count-width helper constants;
  - parameter legality check (DEPTH a power of two, at least 2).
- REQ-029: One sub-module, shift_feed_mem: a DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port, no reset.

Verification
- REQ-030: Reset, then write 0x11, 0x22, 0x33 on consecutive cycles with out_ready = 0 -> count = 3; out_data = 0x11; out_valid = 1 from the cycle after the first write.
- REQ-031: DEPTH = 4, write 0xA0..0xA3, then hold in_valid = 1 with 0xFF -> in_ready = 0; 0xFF never appears at out_data; count stays 4.
- REQ-032: Full FIFO, simultaneous write 0x55 and read -> 0xA0 read; 0x55 rejected; count = 3; in_ready = 1 next cycle.
- REQ-033: Continuous write/read of 0x00..0x0F with out_ready = 1 -> outputs 0x00..0x0F in order, one per cycle after a 1-cycle latency; pointers wrap 4 times; count never exceeds 1.
- REQ-034: Assert reset = 0 with 3 words stored and in_valid = out_ready = 1 -> next cycle count = 0, out_valid = 0, out_data = 0, in_ready = 1.
- REQ-035: SHIFT_FEED_FIFO_FLUSH_EN defined: flush = 1 with a simultaneous write of 0x77 while 2 words are stored -> count = 0; 0x77 is not stored; out_valid = 0 next cycle.
